// File: rtl/block_matmul_scheduler.sv
// Block scheduler for a 4x4 integer matrix product C = A*B built from eight 2x2 block
// multiplies on one shared base multiplier, with local A/B/C register files.
module block_matmul_scheduler #(
  parameter int unsigned w       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_we,
  input  logic         ld_sel,
  input  logic [3:0]   ld_addr,
  input  logic [w-1:0] ld_data,
  input  logic         start,
  input  logic [3:0]   rd_addr,
  output logic [w-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         m_start,
  output logic [w-1:0] m_a11,
  output logic [w-1:0] m_a12,
  output logic [w-1:0] m_a21,
  output logic [w-1:0] m_a22,
  output logic [w-1:0] m_b11,
  output logic [w-1:0] m_b12,
  output logic [w-1:0] m_b21,
  output logic [w-1:0] m_b22,
  input  logic [w-1:0] m_c11,
  input  logic [w-1:0] m_c12,
  input  logic [w-1:0] m_c21,
  input  logic [w-1:0] m_c22,
  input  logic         m_done
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACC} state_e;

  state_e         state_q, state_d;
  logic [2:0]     s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [w-1:0]   a_q [16], a_d [16];
  logic [w-1:0]   b_q [16], b_d [16];
  logic [w-1:0]   c_q [16], c_d [16];
  logic [w-1:0]   mc_q [4], mc_d [4];
  logic [w-1:0]   opa_q [4], opa_d [4];
  logic [w-1:0]   opb_q [4], opb_d [4];
  logic [w-1:0]   rd_data_q, rd_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           m_start_q, m_start_d;

  // Block element (r,c) at step s={i,j,k}: A[{i,r,k,c}], B[{k,r,j,c}], C[{i,r,j,c}].
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    mc_d      = mc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    m_start_d = 1'b0;
    rd_data_d = c_q[rd_addr];

    case (state_q)
      IDLE: begin
        if (ld_we) begin
          if (ld_sel) b_d[ld_addr] = ld_data;
          else        a_d[ld_addr] = ld_data;
        end
        if (start) begin
          err_d   = 1'b0;
          s_d     = 3'd0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving on the last allowed cycle still counts as success.
        if (m_done) begin
          mc_d[0] = m_c11;
          mc_d[1] = m_c12;
          mc_d[2] = m_c21;
          mc_d[3] = m_c22;
          state_d = ACC;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACC: begin
        for (int n = 0; n < 4; n++) begin
          if (s_q[0]) c_d[{s_q[2], n[1], s_q[1], n[0]}] = c_q[{s_q[2], n[1], s_q[1], n[0]}] + mc_q[n];
          else        c_d[{s_q[2], n[1], s_q[1], n[0]}] = mc_q[n];
        end
        if (s_q == 3'd7) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          s_d     = s_q + 3'd1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands and the start pulse are registered on entry to ISSUE so they are valid in that cycle.
    if (state_d == ISSUE) begin
      m_start_d = 1'b1;
      for (int n = 0; n < 4; n++) begin
        opa_d[n] = a_d[{s_d[2], n[1], s_d[0], n[0]}];
        opb_d[n] = b_d[{s_d[0], n[1], s_d[1], n[0]}];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      rd_data_q <= '0;
      for (int n = 0; n < 16; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
      for (int n = 0; n < 4; n++) begin
        mc_q[n]  <= '0;
        opa_q[n] <= '0;
        opb_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      rd_data_q <= rd_data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      mc_q      <= mc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign m_start = m_start_q;
  assign m_a11   = opa_q[0];
  assign m_a12   = opa_q[1];
  assign m_a21   = opa_q[2];
  assign m_a22   = opa_q[3];
  assign m_b11   = opb_q[0];
  assign m_b12   = opb_q[1];
  assign m_b21   = opb_q[2];
  assign m_b22   = opb_q[3];

endmodule
